seq_address_stepper: RTL and testbench
======================================

# seq_address_stepper

Movement-sequence address controller directly downstream of `nextAddressEnabler`. Consumes its one-cycle `enabler` pulse and steps the shared address into the position/time ROMs. Supports start, stop, loop and end-of-sequence control. Emits a delayed `load_pos` strobe, aligned to ROM read latency, so the servo PWM stage latches the new position only when the ROM data is valid.

## Interface
- `ADDR_W`, 6: width of the ROM address.
- `ROM_LAT`, 1: ROM read latency in cycles; legal range 1..4.
- `CLK` input 1: system clock, 50 MHz.
- `RST_N` input 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start` input 1: one-cycle pulse that (re)starts the sequence at address 0.
- `stop` input 1: one-cycle pulse that aborts to IDLE.
- `loop_en` input 1: level; 1 = wrap to 0 after the last step, 0 = finish in DONE.
- `enabler` input 1: one-cycle advance pulse from `nextAddressEnabler`.
- `seq_last` input ADDR_W: last valid address of the sequence; sampled on every step.
- `addr` output ADDR_W: current ROM address, feeding both ROMs.
- `running` output 1: 1 in RUN.
- `load_pos` output 1: one-cycle strobe, ROM_LAT cycles after each `addr` load.
- `done` output 1: one-cycle pulse on entering DONE.
- `wrap_count` output 8: number of completed loops, saturating.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, `addr`=0, `running`=0, `load_pos`=0, `done`=0, `wrap_count`=0, load pipeline cleared.
- IDLE or DONE, `start`=1 → RUN:
  - `addr`←0, `wrap_count`←0, issue a load.
- RUN, `start`=1 → restart as above; any pending `enabler` in the same cycle is ignored.
- RUN, `enabler`=1, `addr`≠`seq_last` → `addr`←`addr`+1, issue a load.
- RUN, `enabler`=1, `addr`==`seq_last`:
  - `loop_en`=1 → `addr`←0, `wrap_count`←`wrap_count`+1 (saturates at 255), issue a load.
  - `loop_en`=0 → DONE, `done` pulse, `running`←0, `addr` holds.
- Address overflow: if `seq_last` was lowered below the current `addr`, the next step wraps by natural ADDR_W overflow. No error is flagged.
- `stop`=1 in any state → IDLE, `addr`←0, load pipeline flushed so no pending `load_pos` fires. `stop` takes priority over `start` and `enabler` in the same cycle.
- `enabler` is ignored outside RUN.
- "Issue a load" injects a 1 at the head of a ROM_LAT-deep shift register. `load_pos` is its tail.
- Back-to-back loads are not possible: `enabler` pulses are spaced at least 20 ms apart.

## Timing
- All outputs are registered.
- Control inputs are sampled at rising edge N; `addr`, `running` and `done` update after edge N.
- `load_pos` is high for exactly the cycle following edge N+ROM_LAT.
- `done` is high for exactly one cycle, following edge N.
- `RST_N` deassertion is synchronized externally; this block assumes it is released away from an edge.

## Configuration
- `SEQ_WRAP_CNT_EN`:
  - Defined: `wrap_count` behaves as described above.
  - Undefined: the counter logic is not built and `wrap_count` is constant 0.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then `start`, `seq_last`=3, `loop_en`=0, four `enabler` pulses:
  - `addr` goes 0,1,2,3, then `done` pulses once and state is DONE.
  - `load_pos` fires 4 times, each 1 cycle after the `addr` change (ROM_LAT=1).
- `loop_en`=1, `seq_last`=2, seven `enabler` pulses:
  - `addr` goes 0,1,2,0,1,2,0,1.
  - `wrap_count`=2; `done` never asserts.
- ROM_LAT=3, `stop` issued 1 cycle after an `addr` step:
  - `addr`=0, state IDLE, and no `load_pos` ever fires for that step.
- `stop` and `enabler` in the same cycle while in RUN → IDLE, `addr`=0, no step taken.
- Loop with `seq_last`=0 for 300 `enabler` pulses → `wrap_count` saturates at 255 with `SEQ_WRAP_CNT_EN` defined, and stays 0 with it undefined.
- `RST_N` pulsed low asynchronously mid-RUN → all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/seq_address_stepper.sv
// -----------------------------------------------------------------------------
// seq_address_stepper
//
// Movement-sequence address controller. It sits directly downstream of
// nextAddressEnabler and walks the shared address of the position/time ROMs
// one step per `enabler` pulse. It supports start, stop, looping and an
// end-of-sequence DONE state. It also emits a `load_pos` strobe delayed to
// match ROM read latency, so the servo PWM stage latches a position only
// when the ROM data is valid.
//
// Parameters
//   ADDR_W   width of the ROM address (default 6)
//   ROM_LAT  ROM read latency in cycles, legal range 1..4 (default 1)
//
// Ports
//   CLK         system clock (50 MHz)
//   RST_N       asynchronous active-low reset (release synchronised upstream)
//   start       pulse: (re)start the sequence at address 0
//   stop        pulse: abort to IDLE; wins over start and enabler
//   loop_en     level: 1 = wrap to 0 after the last step, 0 = finish in DONE
//   enabler     pulse: advance one step (only honoured in RUN)
//   seq_last    last valid address of the sequence, sampled on every step
//   addr        current ROM address
//   running     high while in RUN
//   load_pos    one-cycle strobe, ROM_LAT cycles after each addr load
//   done        one-cycle pulse on entering DONE
//   wrap_count  completed loops, saturating at 255
//
// Build option
//   SEQ_WRAP_CNT_EN  when defined, the loop counter is built. When undefined,
//                    wrap_count is tied to 0 and nothing else changes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module seq_address_stepper #(
  parameter int ADDR_W  = 6,
  parameter int ROM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic              enabler,
  input  logic [ADDR_W-1:0] seq_last,
  output logic [ADDR_W-1:0] addr,
  output logic              running,
  output logic              load_pos,
  output logic              done,
  output logic [7:0]        wrap_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  // Bit 0 is loaded on the edge that loads addr. load_pos is one more
  // register behind the tail, which places the strobe in the cycle after
  // edge N+ROM_LAT.
  logic [ROM_LAT-1:0] load_pipe;

`ifdef SEQ_WRAP_CNT_EN
  logic [7:0] wrap_cnt_q;
  assign wrap_count = wrap_cnt_q;
`else
  assign wrap_count = 8'd0;
`endif

  // NOTE: sequential state uses non-blocking assignments only. Later
  // assignments in this block override the defaults written at its top,
  // which keeps the priority order (stop > start > enabler) readable.
  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: the asynchronous reset clears every register here, including
    // the whole load pipeline, so no stale strobe can leak out after reset.
    if (!RST_N) begin
      state     <= S_IDLE;
      addr      <= '0;
      running   <= 1'b0;
      done      <= 1'b0;
      load_pos  <= 1'b0;
      load_pipe <= '0;
`ifdef SEQ_WRAP_CNT_EN
      wrap_cnt_q <= 8'd0;
`endif
    end else begin
      // Defaults: done is a pulse, and the load pipeline shifts with an
      // empty head unless a load is issued below.
      done     <= 1'b0;
      load_pos <= load_pipe[ROM_LAT-1];
      for (int i = ROM_LAT - 1; i > 0; i--) begin
        load_pipe[i] <= load_pipe[i-1];
      end
      load_pipe[0] <= 1'b0;

      if (stop) begin
        // Flush so a step already in flight never produces a strobe.
        state     <= S_IDLE;
        addr      <= '0;
        running   <= 1'b0;
        load_pos  <= 1'b0;
        load_pipe <= '0;
      end else if (start) begin
        // A same-cycle enabler is intentionally dropped on restart.
        state        <= S_RUN;
        running      <= 1'b1;
        addr         <= '0;
        load_pipe[0] <= 1'b1;
`ifdef SEQ_WRAP_CNT_EN
        wrap_cnt_q   <= 8'd0;
`endif
      end else if (state == S_RUN && enabler) begin
        if (addr != seq_last) begin
          // If seq_last was lowered below addr, this wraps naturally
          // at 2**ADDR_W. No error is flagged for that case.
          addr         <= addr + ADDR_W'(1);
          load_pipe[0] <= 1'b1;
        end else if (loop_en) begin
          addr         <= '0;
          load_pipe[0] <= 1'b1;
`ifdef SEQ_WRAP_CNT_EN
          if (wrap_cnt_q != 8'hFF) begin
            wrap_cnt_q <= wrap_cnt_q + 8'd1;
          end
`endif
        end else begin
          // End of sequence: addr holds on the last position.
          state   <= S_DONE;
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_address_stepper.sv
// -----------------------------------------------------------------------------
// tb_seq_address_stepper
//
// Directed bench for seq_address_stepper. It runs two instances from the
// same stimulus: u_dut1 with ROM_LAT=1 and u_dut3 with ROM_LAT=3. Inputs are
// driven and outputs are sampled on the falling clock edge. Strobes are
// counted on the rising edge, where the value of the cycle just ended is
// stable.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_seq_address_stepper;

  localparam int ADDR_W = 6;

`ifdef SEQ_WRAP_CNT_EN
  localparam bit WC_EN = 1'b1;
`else
  localparam bit WC_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST_N;
  logic              start, stop, loop_en, enabler;
  logic [ADDR_W-1:0] seq_last;

  logic [ADDR_W-1:0] addr1, addr3;
  logic              run1, run3, lp1, lp3, done1, done3;
  logic [7:0]        wc1, wc3;

  int n_checks = 0;
  int n_fail   = 0;
  int lp1_cnt  = 0;
  int lp3_cnt  = 0;
  int done_cnt = 0;
  int base1, base3, base_done;

  always #10 CLK = ~CLK;  // 50 MHz

  seq_address_stepper #(.ADDR_W(ADDR_W), .ROM_LAT(1)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop),
    .loop_en(loop_en), .enabler(enabler), .seq_last(seq_last),
    .addr(addr1), .running(run1), .load_pos(lp1), .done(done1),
    .wrap_count(wc1)
  );

  seq_address_stepper #(.ADDR_W(ADDR_W), .ROM_LAT(3)) u_dut3 (
    .CLK(CLK), .RST_N(RST_N), .start(start), .stop(stop),
    .loop_en(loop_en), .enabler(enabler), .seq_last(seq_last),
    .addr(addr3), .running(run3), .load_pos(lp3), .done(done3),
    .wrap_count(wc3)
  );

  always @(posedge CLK) begin
    if (lp1)   lp1_cnt++;
    if (lp3)   lp3_cnt++;
    if (done1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // One enabler pulse, then enough idle cycles for the ROM_LAT=3 strobe to
  // fire and be counted.
  task automatic step();
    enabler = 1'b1;
    tick();
    enabler = 1'b0;
    repeat (4) tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [ADDR_W-1:0] loop_exp [7];
    loop_exp = '{6'd1, 6'd2, 6'd0, 6'd1, 6'd2, 6'd0, 6'd1};

    RST_N = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    enabler = 1'b0; seq_last = '0;
    repeat (3) tick();
    check("rst_addr",    32'(addr1), 32'd0);
    check("rst_running", 32'(run1),  32'd0);
    check("rst_load",    32'(lp1),   32'd0);
    check("rst_done",    32'(done1), 32'd0);
    check("rst_wc",      32'(wc1),   32'd0);
    RST_N = 1'b1;
    repeat (2) tick();

    // ---- Single pass, seq_last=3, no loop ---------------------------------
    seq_last = 6'd3;
    loop_en  = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    check("start_addr",    32'(addr1), 32'd0);
    check("start_running", 32'(run1),  32'd1);
    check("start_lp1_n",   32'(lp1),   32'd0);
    tick();
    check("start_lp1_n1",  32'(lp1),   32'd1);
    check("start_lp3_n1",  32'(lp3),   32'd0);
    tick();
    check("start_lp1_n2",  32'(lp1),   32'd0);
    tick();
    check("start_lp3_n3",  32'(lp3),   32'd1);
    tick();
    check("start_lp3_n4",  32'(lp3),   32'd0);

    for (int k = 1; k <= 3; k++) begin
      enabler = 1'b1;
      tick();
      enabler = 1'b0;
      check($sformatf("pass_addr%0d", k), 32'(addr1), 32'(k));
      check($sformatf("pass_lp1_pre%0d", k), 32'(lp1), 32'd0);
      tick();
      check($sformatf("pass_lp1_%0d", k), 32'(lp1), 32'd1);
      tick();
      tick();
      check($sformatf("pass_lp3_%0d", k), 32'(lp3), 32'd1);
      tick();
    end

    base_done = done_cnt;
    enabler = 1'b1;
    tick();
    enabler = 1'b0;
    check("end_done",    32'(done1), 32'd1);
    check("end_running", 32'(run1),  32'd0);
    check("end_addr",    32'(addr1), 32'd3);
    tick();
    check("end_done_1cy", 32'(done1), 32'd0);
    repeat (4) tick();
    check("pass_lp1_count",  32'(lp1_cnt), 32'd4);
    check("pass_lp3_count",  32'(lp3_cnt), 32'd4);
    check("pass_done_count", 32'(done_cnt - base_done), 32'd1);

    // enabler is ignored in DONE
    step();
    check("done_ign_addr", 32'(addr1),   32'd3);
    check("done_ign_lp",   32'(lp1_cnt), 32'd4);

    // ---- Looping, seq_last=2 ----------------------------------------------
    loop_en  = 1'b1;
    seq_last = 6'd2;
    pulse_start();
    check("loop_start_addr", 32'(addr1), 32'd0);
    check("loop_start_run",  32'(run1),  32'd1);
    base1 = lp1_cnt;
    base_done = done_cnt;
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("loop_addr%0d", k), 32'(addr1), 32'(loop_exp[k]));
    end
    check("loop_wc",    32'(wc1), WC_EN ? 32'd2 : 32'd0);
    check("loop_wc3",   32'(wc3), WC_EN ? 32'd2 : 32'd0);
    check("loop_done",  32'(done_cnt - base_done), 32'd0);
    check("loop_lp1",   32'(lp1_cnt - base1), 32'd7);

    // ---- stop one cycle after a step, pending loads flushed ---------------
    base1 = lp1_cnt;
    base3 = lp3_cnt;
    enabler = 1'b1;
    tick();
    enabler = 1'b0;
    check("stop_pre_addr", 32'(addr3), 32'd2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_addr3",    32'(addr3), 32'd0);
    check("stop_addr1",    32'(addr1), 32'd0);
    check("stop_running3", 32'(run3),  32'd0);
    repeat (6) tick();
    check("stop_lp3_none", 32'(lp3_cnt - base3), 32'd0);
    check("stop_lp1_none", 32'(lp1_cnt - base1), 32'd0);
    // enabler is ignored in IDLE
    step();
    check("idle_ign_addr", 32'(addr1), 32'd0);
    check("idle_ign_lp",   32'(lp1_cnt - base1), 32'd0);

    // start and stop together: stop wins
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_run", 32'(run1), 32'd0);
    repeat (4) tick();
    check("start_stop_lp",  32'(lp1_cnt - base1), 32'd0);

    // ---- stop and enabler in the same cycle while in RUN ------------------
    seq_last = 6'd5;
    pulse_start();
    step();
    check("se_pre_addr", 32'(addr1), 32'd1);
    base1 = lp1_cnt;
    base3 = lp3_cnt;
    stop    = 1'b1;
    enabler = 1'b1;
    tick();
    stop    = 1'b0;
    enabler = 1'b0;
    check("se_addr",    32'(addr1), 32'd0);
    check("se_running", 32'(run1),  32'd0);
    repeat (5) tick();
    check("se_lp1", 32'(lp1_cnt - base1), 32'd0);
    check("se_lp3", 32'(lp3_cnt - base3), 32'd0);

    // ---- wrap_count saturation, seq_last=0 --------------------------------
    seq_last = 6'd0;
    loop_en  = 1'b1;
    pulse_start();
    for (int k = 0; k < 300; k++) begin
      enabler = 1'b1;
      tick();
      enabler = 1'b0;
      tick();
      if (k == 254) begin
        check("sat_wc_255", 32'(wc1), WC_EN ? 32'd255 : 32'd0);
      end
    end
    check("sat_wc_300",  32'(wc1),   WC_EN ? 32'd255 : 32'd0);
    check("sat_addr",    32'(addr1), 32'd0);
    check("sat_running", 32'(run1),  32'd1);

    // ---- asynchronous reset mid-RUN ---------------------------------------
    seq_last = 6'd5;
    step();
    enabler = 1'b1;
    tick();
    enabler = 1'b0;
    check("ar_pre_addr", 32'(addr3), 32'd2);
    base3 = lp3_cnt;
    #3;
    RST_N = 1'b0;
    #1;  // well before the next rising edge
    check("ar_addr1",   32'(addr1), 32'd0);
    check("ar_addr3",   32'(addr3), 32'd0);
    check("ar_running", 32'(run1),  32'd0);
    check("ar_done",    32'(done1), 32'd0);
    check("ar_load",    32'(lp3),   32'd0);
    check("ar_wc",      32'(wc1),   32'd0);
    tick();
    RST_N = 1'b1;
    repeat (5) tick();
    check("ar_lp3_none", 32'(lp3_cnt - base3), 32'd0);
    check("ar_idle_run", 32'(run3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
